// File: rtl/syn_tx.sv
// Timing-sync serial transmitter: on each accepted second pulse it sends a long low
// sync marker, an idle gap, then HEAD, the 4 UTC second bytes (MSB first) and a checksum.
module syn_tx #(
    parameter int         SYN_BITS = 12,
    parameter int         GAP_BITS = 2,
    parameter logic [7:0] HEAD     = 8'hA5
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [19:0] tbit_period,
    input  logic        tx_en,
    input  logic        pps_in,
    input  logic [31:0] utc_sec_in,
    output logic        tx_syn,
    output logic        tx_busy,
    output logic [7:0]  stu_err_tx
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SYNC  = 3'd1;
    localparam logic [2:0] GAP   = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] DATA  = 3'd4;
    localparam logic [2:0] STOP  = 3'd5;

    localparam logic [7:0] SYN_LAST = 8'(SYN_BITS - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_BITS - 1);

    logic [2:0]  state_reg;
    logic [19:0] t_reg;
    logic [31:0] sec_reg;
    logic [19:0] bit_cnt_reg;
    logic [7:0]  bit_idx_reg;
    logic [2:0]  byte_idx_reg;
    logic [7:0]  shift_reg;

    logic [7:0]  sec_byte [4];
    logic [7:0]  chk;
    logic [2:0]  nxt_idx;
    logic [7:0]  next_byte;
    logic        bit_end;

    for (genvar gi = 0; gi < 4; gi++) begin : g_sec_byte
        assign sec_byte[gi] = sec_reg[31-8*gi -: 8];
    end

    assign chk     = sec_byte[0] + sec_byte[1] + sec_byte[2] + sec_byte[3];
    assign nxt_idx = byte_idx_reg + 3'd1;
    assign bit_end = (bit_cnt_reg == t_reg - 20'd1);

    // Byte that follows the one currently on the line.
    always_comb begin
        next_byte = HEAD;
        case (nxt_idx)
            3'd1:    next_byte = sec_byte[0];
            3'd2:    next_byte = sec_byte[1];
            3'd3:    next_byte = sec_byte[2];
            3'd4:    next_byte = sec_byte[3];
            3'd5:    next_byte = chk;
            default: next_byte = HEAD;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            t_reg        <= '0;
            sec_reg      <= '0;
            bit_cnt_reg  <= '0;
            bit_idx_reg  <= '0;
            byte_idx_reg <= '0;
            shift_reg    <= '0;
            tx_syn       <= 1'b1;
            tx_busy      <= 1'b0;
            stu_err_tx   <= '0;
        end else begin
            // Any strobe seen outside IDLE is an overrun, including the final stop-bit cycle.
            if (pps_in && state_reg != IDLE && stu_err_tx != 8'hFF)
                stu_err_tx <= stu_err_tx + 8'd1;

            if (state_reg == IDLE) begin
                if (pps_in && tx_en) begin
                    state_reg   <= SYNC;
                    sec_reg     <= utc_sec_in;
                    t_reg       <= (tbit_period < 20'd2) ? 20'd2 : tbit_period;
                    bit_cnt_reg <= '0;
                    bit_idx_reg <= '0;
                    tx_syn      <= 1'b0;
                    tx_busy     <= 1'b1;
                end
            end else if (!bit_end) begin
                bit_cnt_reg <= bit_cnt_reg + 20'd1;
            end else begin
                bit_cnt_reg <= '0;
                case (state_reg)
                    SYNC: begin
                        if (bit_idx_reg == SYN_LAST) begin
                            state_reg   <= GAP;
                            bit_idx_reg <= '0;
                            tx_syn      <= 1'b1;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 8'd1;
                        end
                    end
                    GAP: begin
                        if (bit_idx_reg == GAP_LAST) begin
                            state_reg    <= START;
                            byte_idx_reg <= '0;
                            shift_reg    <= HEAD;
                            tx_syn       <= 1'b0;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 8'd1;
                        end
                    end
                    START: begin
                        state_reg   <= DATA;
                        bit_idx_reg <= '0;
                        tx_syn      <= shift_reg[0];
                    end
                    DATA: begin
                        if (bit_idx_reg == 8'd7) begin
                            state_reg <= STOP;
                            tx_syn    <= 1'b1;
                        end else begin
                            shift_reg   <= shift_reg >> 1;
                            tx_syn      <= shift_reg[1];
                            bit_idx_reg <= bit_idx_reg + 8'd1;
                        end
                    end
                    STOP: begin
                        if (byte_idx_reg == 3'd5) begin
                            state_reg <= IDLE;
                            tx_busy   <= 1'b0;
                        end else begin
                            state_reg    <= START;
                            byte_idx_reg <= nxt_idx;
                            shift_reg    <= next_byte;
                            tx_syn       <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        tx_syn    <= 1'b1;
                        tx_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
